// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage (master) and the data memory/bus (slave).
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: ALU pass-through, req/ack data-bus transactions with
// byte-lane steering, load extension, alignment exceptions and pipeline stall.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic [31:0] ex_wdata,
    input  logic        ex_wreg,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_maddr,
    input  logic [31:0] ex_sdata,
    output logic [4:0]  mem_wd,
    output logic [31:0] mem_wdata,
    output logic        mem_wreg,
    output logic        mem_excp,
    output logic        stallreq,
    mem_stage_if.master dbus
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_ldata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_capture;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [3:0]  w_lane_be;
    logic [31:0] w_lane_wdata;
    logic [31:0] w_lext;

    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_bwdata;

    assign w_is_load  = (ex_memop >= OP_LB) && (ex_memop <= OP_LW);
    assign w_is_store = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
    assign w_is_mem   = w_is_load || w_is_store;

    always_comb begin
        w_misaligned = 1'b0;
        case (ex_memop)
            OP_LH, OP_LHU, OP_SH: w_misaligned = ex_maddr[0];
            OP_LW, OP_SW:         w_misaligned = |ex_maddr[1:0];
            default:              w_misaligned = 1'b0;
        endcase
    end

    // Little-endian lane selection of the returned word.
    always_comb begin
        w_rbyte = dbus.dbus_rdata[7:0];
        case (ex_maddr[1:0])
            2'd0: w_rbyte = dbus.dbus_rdata[7:0];
            2'd1: w_rbyte = dbus.dbus_rdata[15:8];
            2'd2: w_rbyte = dbus.dbus_rdata[23:16];
            2'd3: w_rbyte = dbus.dbus_rdata[31:24];
            default: w_rbyte = dbus.dbus_rdata[7:0];
        endcase
    end

    assign w_rhalf = ex_maddr[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_lane_be    = 4'b0000;
        w_lane_wdata = 32'h0;
        w_lext       = 32'h0;
        case (ex_memop)
            OP_LB: begin
                w_lane_be = 4'b0001 << ex_maddr[1:0];
                w_lext    = {{24{w_rbyte[7]}}, w_rbyte};
            end
            OP_LBU: begin
                w_lane_be = 4'b0001 << ex_maddr[1:0];
                w_lext    = {24'h0, w_rbyte};
            end
            OP_LH: begin
                w_lane_be = ex_maddr[1] ? 4'b1100 : 4'b0011;
                w_lext    = {{16{w_rhalf[15]}}, w_rhalf};
            end
            OP_LHU: begin
                w_lane_be = ex_maddr[1] ? 4'b1100 : 4'b0011;
                w_lext    = {16'h0, w_rhalf};
            end
            OP_LW: begin
                w_lane_be = 4'b1111;
                w_lext    = dbus.dbus_rdata;
            end
            OP_SB: begin
                w_lane_be    = 4'b0001 << ex_maddr[1:0];
                w_lane_wdata = {4{ex_sdata[7:0]}};
            end
            OP_SH: begin
                w_lane_be    = ex_maddr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{ex_sdata[15:0]}};
            end
            OP_SW: begin
                w_lane_be    = 4'b1111;
                w_lane_wdata = ex_sdata;
            end
            default: begin
                w_lane_be    = 4'b0000;
                w_lane_wdata = 32'h0;
                w_lext       = 32'h0;
            end
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        mem_wd       = ex_wd;
        mem_wdata    = ex_wdata;
        mem_wreg     = ex_wreg;
        mem_excp     = 1'b0;
        stallreq     = 1'b0;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = 32'h0;
        w_be         = 4'b0000;
        w_bwdata     = 32'h0;

        case (r_state)
            S_DONE: begin
                // Always back to IDLE so the held ex_mem op is never reissued.
                w_next_state = S_IDLE;
                mem_wdata    = w_is_load ? r_ldata : ex_wdata;
            end
            default: begin
                if (w_is_mem) begin
                    mem_wreg = 1'b0;
                    if (w_misaligned) begin
                        mem_excp     = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        stallreq = 1'b1;
                        w_req    = 1'b1;
                        w_we     = w_is_store;
                        w_addr   = {ex_maddr[31:2], 2'b00};
                        w_be     = w_lane_be;
                        w_bwdata = w_lane_wdata;
                        if (dbus.dbus_ack) begin
                            w_next_state = S_DONE;
                            w_capture    = 1'b1;
                        end else begin
                            w_next_state = S_BUSY;
                        end
                    end
                end
            end
        endcase

        // Reset silences every output at once, abandoning any open request.
        if (!rst) begin
            mem_wd    = 5'h0;
            mem_wdata = 32'h0;
            mem_wreg  = 1'b0;
            mem_excp  = 1'b0;
            stallreq  = 1'b0;
            w_req     = 1'b0;
            w_we      = 1'b0;
            w_addr    = 32'h0;
            w_be      = 4'b0000;
            w_bwdata  = 32'h0;
        end
    end

    assign dbus.dbus_req   = w_req;
    assign dbus.dbus_we    = w_we;
    assign dbus.dbus_addr  = w_addr;
    assign dbus.dbus_be    = w_be;
    assign dbus.dbus_wdata = w_bwdata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ldata <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_ldata <= w_is_load ? w_lext : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single-ack transfers plus
// hand-written multi-cycle sequences (wait states, reset mid-transfer, back-to-back stores).
module tb_mem_stage;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata;
    logic        ex_wreg;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_wreg;
    logic        mem_excp;
    logic        stallreq;

    mem_stage_if bus ();

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .ex_wd     (ex_wd),
        .ex_wdata  (ex_wdata),
        .ex_wreg   (ex_wreg),
        .ex_memop  (ex_memop),
        .ex_maddr  (ex_maddr),
        .ex_sdata  (ex_sdata),
        .mem_wd    (mem_wd),
        .mem_wdata (mem_wdata),
        .mem_wreg  (mem_wreg),
        .mem_excp  (mem_excp),
        .stallreq  (stallreq),
        .dbus      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    typedef struct {
        logic [3:0]  memop;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic        wreg;
        logic        exp_req;
        logic        exp_excp;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[16];

    task automatic drive_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] wd, input logic [31:0] alu, input logic wreg);
        ex_memop = op;
        ex_maddr = addr;
        ex_sdata = sdata;
        ex_wd    = wd;
        ex_wdata = alu;
        ex_wreg  = wreg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // memop addr sdata rdata alu wreg | req excp we be bwdata result
        vecs[0]  = '{4'd1, 32'h203, 32'h0,        32'h80123456, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{4'd2, 32'h203, 32'h0,        32'h80123456, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        vecs[2]  = '{4'd1, 32'h201, 32'h0,        32'h00007F00, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h0,        32'h0000007F};
        vecs[3]  = '{4'd3, 32'h102, 32'h0,        32'h80017FFF, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[4]  = '{4'd4, 32'h100, 32'h0,        32'h8001F00D, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
        vecs[5]  = '{4'd3, 32'h104, 32'h0,        32'h12347FFF, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h0,        32'h00007FFF};
        vecs[6]  = '{4'd5, 32'h104, 32'h0,        32'h12345678, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h12345678};
        vecs[7]  = '{4'd6, 32'h302, 32'h000000A5, 32'h0,        32'h22222222, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 32'hA5A5A5A5, 32'h22222222};
        vecs[8]  = '{4'd7, 32'h306, 32'h1234ABCD, 32'h0,        32'h33333333, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h33333333};
        vecs[9]  = '{4'd8, 32'h308, 32'h11223344, 32'h0,        32'h44444444, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h11223344, 32'h44444444};
        vecs[10] = '{4'd5, 32'h102, 32'h0,        32'h0,        32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{4'd7, 32'h301, 32'h0,        32'h0,        32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{4'd4, 32'h103, 32'h0,        32'h0,        32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{4'd9, 32'h102, 32'h0,        32'h0,        32'h55555555, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h55555555};
        vecs[14] = '{4'd0, 32'h0,   32'h0,        32'h0,        32'h66666666, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h66666666};
        vecs[15] = '{4'd6, 32'h301, 32'h0000007E, 32'h0,        32'h77777777, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 32'h7E7E7E7E, 32'h77777777};

        // Reset: outputs forced to zero even with a memory op pending.
        rst = 1'b0;
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = JUNK;
        drive_op(4'd5, 32'h100, 32'h0, 5'd3, 32'h99, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_req", bus.dbus_req, 1'b0);
        check1("rst_stall", stallreq, 1'b0);
        check1("rst_wreg", mem_wreg, 1'b0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wd", 32'(mem_wd), 32'h0);
        step();
        rst = 1'b1;
        drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);

        // Table: every transfer acked in its first cycle; ack held during non-requests too.
        for (int i = 0; i < 16; i++) begin
            step();
            drive_op(vecs[i].memop, vecs[i].addr, vecs[i].sdata, 5'(i + 1), vecs[i].alu, vecs[i].wreg);
            bus.dbus_ack   = 1'b1;
            bus.dbus_rdata = vecs[i].rdata;
            @(negedge clk);
            check1($sformatf("v%0d_req", i), bus.dbus_req, vecs[i].exp_req);
            check1($sformatf("v%0d_stall", i), stallreq, vecs[i].exp_req);
            check1($sformatf("v%0d_excp", i), mem_excp, vecs[i].exp_excp);
            if (vecs[i].exp_req || vecs[i].exp_excp) begin
                check1($sformatf("v%0d_wreg_c1", i), mem_wreg, 1'b0);
            end else begin
                check1($sformatf("v%0d_wreg", i), mem_wreg, vecs[i].wreg);
                check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_result);
                check($sformatf("v%0d_wd", i), 32'(mem_wd), 32'(i + 1));
            end
            if (vecs[i].exp_req) begin
                check1($sformatf("v%0d_we", i), bus.dbus_we, vecs[i].exp_we);
                check($sformatf("v%0d_be", i), 32'(bus.dbus_be), 32'(vecs[i].exp_be));
                check($sformatf("v%0d_bwdata", i), bus.dbus_wdata, vecs[i].exp_bwdata);
                check($sformatf("v%0d_addr", i), bus.dbus_addr, {vecs[i].addr[31:2], 2'b00});
                step();
                bus.dbus_ack   = 1'b0;
                bus.dbus_rdata = JUNK;
                @(negedge clk);
                check1($sformatf("v%0d_done_req", i), bus.dbus_req, 1'b0);
                check1($sformatf("v%0d_done_stall", i), stallreq, 1'b0);
                check1($sformatf("v%0d_done_wreg", i), mem_wreg, vecs[i].wreg);
                check($sformatf("v%0d_done_wdata", i), mem_wdata, vecs[i].exp_result);
                check($sformatf("v%0d_done_wd", i), 32'(mem_wd), 32'(i + 1));
            end
        end
        step();
        drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        bus.dbus_ack = 1'b0;

        // LW with two wait states: ack arrives in the third request cycle.
        step();
        drive_op(4'd5, 32'h100, 32'h0, 5'd9, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            if (c == 2) begin
                bus.dbus_ack   = 1'b1;
                bus.dbus_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            check1($sformatf("lw3_stall%0d", c), stallreq, 1'b1);
            check1($sformatf("lw3_req%0d", c), bus.dbus_req, 1'b1);
            check($sformatf("lw3_addr%0d", c), bus.dbus_addr, 32'h100);
            check($sformatf("lw3_be%0d", c), 32'(bus.dbus_be), 32'hF);
            check1($sformatf("lw3_wreg%0d", c), mem_wreg, 1'b0);
        end
        step();
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = JUNK;
        @(negedge clk);
        check1("lw3_done_stall", stallreq, 1'b0);
        check1("lw3_done_req", bus.dbus_req, 1'b0);
        check("lw3_done_wdata", mem_wdata, 32'hDEADBEEF);
        check1("lw3_done_wreg", mem_wreg, 1'b1);
        check("lw3_done_wd", 32'(mem_wd), 32'd9);
        step();
        drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);

        // Reset asserted in the second BUSY cycle drops the request at once.
        step();
        drive_op(4'd5, 32'h200, 32'h0, 5'd4, 32'h0, 1'b1);
        @(negedge clk);
        check1("rb_req_idle", bus.dbus_req, 1'b1);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check1("rb_req", bus.dbus_req, 1'b0);
        check1("rb_stall", stallreq, 1'b0);
        step();
        rst = 1'b1;
        drive_op(4'd0, 32'h0, 32'h0, 5'd5, 32'd7, 1'b1);
        @(negedge clk);
        check("rb_alu_wd", 32'(mem_wd), 32'd5);
        check("rb_alu_wdata", mem_wdata, 32'd7);
        check1("rb_alu_wreg", mem_wreg, 1'b1);
        check1("rb_alu_req", bus.dbus_req, 1'b0);

        // Two back-to-back SWs with ack held high: request only in IDLE cycles.
        step();
        drive_op(4'd8, 32'h400, 32'hA5A5F00F, 5'd0, 32'h0, 1'b0);
        bus.dbus_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            @(negedge clk);
            check1($sformatf("sw2_req%0d", c), bus.dbus_req, (c % 2) == 0);
            check1($sformatf("sw2_we%0d", c), bus.dbus_we, (c % 2) == 0);
            check1($sformatf("sw2_stall%0d", c), stallreq, (c % 2) == 0);
        end

        // Ack while no request is ignored: a following LW must wait for its own ack.
        step();
        drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        bus.dbus_ack = 1'b1;
        @(negedge clk);
        check1("ign_req0", bus.dbus_req, 1'b0);
        step();
        drive_op(4'd5, 32'h500, 32'h0, 5'd12, 32'h0, 1'b1);
        bus.dbus_ack = 1'b0;
        @(negedge clk);
        check1("ign_req1", bus.dbus_req, 1'b1);
        step();
        bus.dbus_ack   = 1'b1;
        bus.dbus_rdata = 32'h00000042;
        @(negedge clk);
        check1("ign_req2", bus.dbus_req, 1'b1);
        check1("ign_stall2", stallreq, 1'b1);
        step();
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = JUNK;
        @(negedge clk);
        check("ign_done_wdata", mem_wdata, 32'h00000042);
        check1("ign_done_wreg", mem_wreg, 1'b1);
        check1("ign_done_req", bus.dbus_req, 1'b0);

        step();
        drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the ex_mem pipeline register and the mem_wb register. It passes ALU results through unchanged. For loads and stores it runs a request/acknowledge transaction on the data bus, stalling the pipeline until the bus acknowledges. It performs byte-lane steering, sign/zero extension and alignment checking, and presents the destination register, write data and write enable that mem_wb captures.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-low
- ex_wd  in  5  destination register from ex_mem
- ex_wdata  in  32  ALU result / non-memory write data
- ex_wreg  in  1  register write enable
- ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- ex_maddr  in  32  effective byte address
- ex_sdata  in  32  store data (rt)
- mem_wd  out  5  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_excp  out  1  address-misalignment exception, to pipeline control
- stallreq  out  1  stall request to pipeline control; holds ex_mem inputs stable
- dbus_req  out  1  bus request
- dbus_we  out  1  1 store, 0 load
- dbus_addr  out  32  {ex_maddr[31:2],2'b00}
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_rdata  in  32  load data, valid when dbus_ack=1
- dbus_ack  in  1  transfer complete; sampled at posedge while dbus_req=1

## Operation
- States: IDLE, BUSY, DONE. Registers: state, ldata[31:0] (extended load result).
- Non-memory op (memop none), any state except DONE: mem_wd/wdata/wreg = ex_wd/ex_wdata/ex_wreg combinationally. No bus activity. stallreq=0.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. In IDLE: mem_excp=1, dbus_req=0, mem_wreg=0, stallreq=0. State stays IDLE.
- Aligned memory op in IDLE or BUSY:
  - dbus_req=1, stallreq=1, mem_wreg=0.
  - On dbus_ack: state goes to DONE, and ldata captures the extended load data (stores capture 0).
  - Without ack: IDLE goes to BUSY, and BUSY stays in BUSY.
- DONE: dbus_req=0, stallreq=0, mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata = ldata for loads and ex_wdata for stores. Next state is IDLE unconditionally, so the same op is never reissued.
- Byte lanes (little-endian), k=addr[1:0], h=addr[1]:
  - LB/LBU: be=1<<k; data=rdata[8k+7:8k], sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: be=h?4'b1100:4'b0011; data=rdata[16h+15:16h], sign-extended (LH) or zero-extended (LHU).
  - LW: be=4'b1111.
  - SB: wdata={4{sdata[7:0]}}.
  - SH: wdata={2{sdata[15:0]}}.
  - SW: wdata=sdata. Store enables match the corresponding load.
- Outside a request, dbus_we/be/wdata are 0.

## Timing
- Reset, rst=0 at posedge: state=IDLE, ldata=0.
  - While rst=0, all outputs are forced 0 combinationally.
  - Reset mid-BUSY drops the request immediately. The bus is required to tolerate an abandoned request.
- Memory op latency:
  - 1+N cycles with stallreq=1, where N is the number of BUSY cycles.
  - Minimum 2 cycles: ack in the first cycle gives IDLE -> DONE, 1 stall cycle.
  - The result is presented in DONE and captured by mem_wb at the edge ending DONE.
- dbus_req stays high, with address/be/we/wdata stable, from issue until the ack edge. It falls in DONE.
- mem_excp lasts exactly 1 cycle, with no stall.
- Back-to-back memory ops: DONE -> IDLE, and the next op issues in IDLE the cycle after DONE. This gives 1 idle bus cycle between transfers.
- dbus_ack while dbus_req=0 is ignored.

## Test plan
- LW addr 0x100, ack on 3rd request cycle, rdata=0xDEADBEEF:
  - stallreq high 3 cycles, then DONE.
  - mem_wdata=0xDEADBEEF, mem_wreg=1, dbus_addr=0x100, be=1111.
- LB addr 0x203, rdata=0x80xxxxxx, ack in first cycle -> be=1000, mem_wdata=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH addr 0x306, sdata=0x1234ABCD -> dbus_we=1, be=1100, wdata=0xABCDABCD, mem_wreg=0.
- LW addr 0x102 -> mem_excp=1 for 1 cycle, dbus_req=0, stallreq=0, mem_wreg=0.
- Reset asserted on 2nd BUSY cycle -> next cycle dbus_req=0, stallreq=0. After release, ALU op ex_wd=5, ex_wdata=7 passes through with mem_wreg=1.
- Two consecutive SW ops, each acked immediately -> req pattern 1,0,1,0 across IDLE, DONE, IDLE, DONE. No duplicate store.
